// File: rtl/rgb2hsv_div_prep.sv
// HSV front end: RGB888 pixels in, hue/saturation dividend-divisor pairs, sector base, sign, V and grey flag out.
// Fixed 3-cycle latency. One pixel per clock, no back-pressure; syncs are delay-matched to the data.
module rgb2hsv_div_prep #(
  parameter int DW = 8,
  parameter int N  = 24
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          i_de,
  input  logic [DW-1:0] i_r,
  input  logic [DW-1:0] i_g,
  input  logic [DW-1:0] i_b,
  output logic [N-1:0]  o_hue_dividend,
  output logic [N-1:0]  o_hue_divisor,
  output logic [N-1:0]  o_sat_dividend,
  output logic [N-1:0]  o_sat_divisor,
  output logic [8:0]    o_hue_base,
  output logic          o_hue_neg,
  output logic [DW-1:0] o_value,
  output logic          o_achrom,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de
);

  localparam logic [N-1:0] HUE_K = N'(60);
  localparam logic [N-1:0] SAT_K = N'(255);

  // stage 1: input registers
  logic [DW-1:0] r1, g1, b1;
  logic          hs1, vs1, de1;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      de1 <= 1'b0;
    end else begin
      r1  <= i_r;
      g1  <= i_g;
      b1  <= i_b;
      hs1 <= i_hs;
      vs1 <= i_vs;
      de1 <= i_de;
    end
  end

  // stage 2: max/min/sector; the diff operands are picked per sector so
  // |diff| and its sign come from one unsigned compare-and-subtract
  logic [DW-1:0] mx_c, mn_c, pa_c, pb_c, absd_c;
  logic [8:0]    base_c;
  logic          neg_c;

  always_comb begin
    mn_c = r1;
    if (g1 < mn_c) mn_c = g1;
    if (b1 < mn_c) mn_c = b1;
    if (r1 >= g1 && r1 >= b1) begin
      mx_c   = r1;
      pa_c   = g1;
      pb_c   = b1;
      base_c = 9'd0;
    end else if (g1 >= b1) begin
      mx_c   = g1;
      pa_c   = b1;
      pb_c   = r1;
      base_c = 9'd120;
    end else begin
      mx_c   = b1;
      pa_c   = r1;
      pb_c   = g1;
      base_c = 9'd240;
    end
    neg_c  = pa_c < pb_c;
    absd_c = neg_c ? (pb_c - pa_c) : (pa_c - pb_c);
  end

  logic [DW-1:0] absd2, mx2, mn2;
  logic [8:0]    base2;
  logic          neg2, hs2, vs2, de2;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      absd2 <= '0;
      mx2   <= '0;
      mn2   <= '0;
      base2 <= '0;
      neg2  <= 1'b0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      de2   <= 1'b0;
    end else begin
      absd2 <= absd_c;
      mx2   <= mx_c;
      mn2   <= mn_c;
      base2 <= base_c;
      neg2  <= neg_c;
      hs2   <= hs1;
      vs2   <= vs1;
      de2   <= de1;
    end
  end

  // stage 3: products and divide-by-zero guards, registered straight onto the outputs
  logic [DW-1:0] delta3;
  logic          grey3, dark3;

  always_comb begin
    delta3 = mx2 - mn2;
    grey3  = (delta3 == '0);
    dark3  = (mx2 == '0);
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      o_hue_dividend <= '0;
      o_hue_divisor  <= '0;
      o_sat_dividend <= '0;
      o_sat_divisor  <= '0;
      o_hue_base     <= '0;
      o_hue_neg      <= 1'b0;
      o_value        <= '0;
      o_achrom       <= 1'b0;
      o_hsync        <= 1'b0;
      o_vsync        <= 1'b0;
      o_de           <= 1'b0;
    end else begin
      o_hsync <= hs2;
      o_vsync <= vs2;
      o_de    <= de2;
      if (!de2) begin
        o_hue_dividend <= '0;
        o_hue_divisor  <= '0;
        o_sat_dividend <= '0;
        o_sat_divisor  <= '0;
        o_hue_base     <= '0;
        o_hue_neg      <= 1'b0;
        o_value        <= '0;
        o_achrom       <= 1'b0;
      end else begin
        o_hue_dividend <= grey3 ? '0 : N'(absd2) * HUE_K;
        o_hue_divisor  <= grey3 ? N'(1) : N'(delta3);
        o_hue_neg      <= neg2 & ~grey3;
        o_sat_dividend <= dark3 ? '0 : N'(delta3) * SAT_K;
        o_sat_divisor  <= dark3 ? N'(1) : N'(mx2);
        o_hue_base     <= base2;
        o_value        <= mx2;
        o_achrom       <= grey3;
      end
    end
  end

endmodule

// File: tb/tb_rgb2hsv_div_prep.sv
// Scoreboard bench for rgb2hsv_div_prep: driver pushes model results, negedge monitor pops and compares.
module tb_rgb2hsv_div_prep;

  logic        pixelclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
  logic [23:0] o_hue_dividend, o_hue_divisor, o_sat_dividend, o_sat_divisor;
  logic [8:0]  o_hue_base;
  logic        o_hue_neg, o_achrom, o_hsync, o_vsync, o_de;
  logic [7:0]  o_value;

  rgb2hsv_div_prep #(.DW(8), .N(24)) dut (
    .pixelclk(pixelclk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_hue_dividend(o_hue_dividend), .o_hue_divisor(o_hue_divisor),
    .o_sat_dividend(o_sat_dividend), .o_sat_divisor(o_sat_divisor),
    .o_hue_base(o_hue_base), .o_hue_neg(o_hue_neg), .o_value(o_value),
    .o_achrom(o_achrom), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct packed {
    logic        hs, vs, de;
    logic [23:0] hd, hdv, sd, sdv;
    logic [8:0]  base;
    logic        neg;
    logic [7:0]  val;
    logic        ach;
  } px_t;

  px_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference: HSV division operands straight from the colour-space definition
  function automatic px_t model(input logic hs, vs, de, input logic [7:0] r, g, b);
    px_t e;
    int  ri, gi, bi, mx, mn, delta, diff, base;
    e = '0;
    e.hs = hs; e.vs = vs; e.de = de;
    if (!de) return e;
    ri = int'(r); gi = int'(g); bi = int'(b);
    mx = ri; if (gi > mx) mx = gi; if (bi > mx) mx = bi;
    mn = ri; if (gi < mn) mn = gi; if (bi < mn) mn = bi;
    delta = mx - mn;
    if (ri == mx)      begin diff = gi - bi; base = 0;   end
    else if (gi == mx) begin diff = bi - ri; base = 120; end
    else               begin diff = ri - gi; base = 240; end
    if (delta == 0) begin
      e.hd = 24'd0; e.hdv = 24'd1; e.neg = 1'b0; e.ach = 1'b1;
    end else begin
      e.hd  = 24'((diff < 0 ? -diff : diff) * 60);
      e.hdv = 24'(delta);
      e.neg = diff < 0;
      e.ach = 1'b0;
    end
    if (mx == 0) begin e.sd = 24'd0; e.sdv = 24'd1; end
    else begin e.sd = 24'(delta * 255); e.sdv = 24'(mx); end
    e.base = 9'(base);
    e.val  = 8'(mx);
    return e;
  endfunction

  always @(negedge pixelclk) begin
    px_t a, e;
    a = {o_hsync, o_vsync, o_de, o_hue_dividend, o_hue_divisor, o_sat_dividend,
         o_sat_divisor, o_hue_base, o_hue_neg, o_value, o_achrom};
    if (!rst_n) begin
      n_cmp++;
      if (a !== '0) begin
        n_bad++;
        $display("FAIL reset_zero t=%0t got=%h required=0", $time, a);
      end
    end else if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL pixel t=%0t got hs/vs/de=%b%b%b hd=%0d hdv=%0d sd=%0d sdv=%0d base=%0d neg=%b v=%0d ach=%b required hs/vs/de=%b%b%b hd=%0d hdv=%0d sd=%0d sdv=%0d base=%0d neg=%b v=%0d ach=%b",
                 $time, a.hs, a.vs, a.de, a.hd, a.hdv, a.sd, a.sdv, a.base, a.neg, a.val, a.ach,
                 e.hs, e.vs, e.de, e.hd, e.hdv, e.sd, e.sdv, e.base, e.neg, e.val, e.ach);
      end
    end
  end

  task automatic drive(input logic hs, vs, de, input logic [7:0] r, g, b);
    @(posedge pixelclk);
    #1;
    i_hs = hs; i_vs = vs; i_de = de; i_r = r; i_g = g; i_b = b;
    sbq.push_back(model(hs, vs, de, r, g, b));
  endtask

  // Pipeline holds three cleared stages at release, then the pixel already on the inputs
  task automatic release_rst();
    @(posedge pixelclk);
    #1;
    sbq.delete();
    repeat (3) sbq.push_back('0);
    sbq.push_back(model(i_hs, i_vs, i_de, i_r, i_g, i_b));
    rst_n = 1'b1;
  endtask

  task automatic assert_rst(input int cycles);
    @(posedge pixelclk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    repeat (cycles - 1) @(posedge pixelclk);
    release_rst();
  endtask

  task automatic rand_px(input int maxv);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv)));
  endtask

  initial begin
    repeat (2) @(posedge pixelclk);
    release_rst();

    drive(1'b0, 1'b0, 1'b1, 8'd200, 8'd100, 8'd50);
    drive(1'b0, 1'b0, 1'b1, 8'd10,  8'd20,  8'd250);
    drive(1'b0, 1'b0, 1'b1, 8'd128, 8'd128, 8'd128);
    drive(1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   8'd0);
    drive(1'b0, 1'b0, 1'b1, 8'd255, 8'd255, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 8'd30,  8'd90,  8'd90);
    drive(1'b1, 1'b0, 1'b0, 8'd77,  8'd12,  8'd200);
    drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd255);

    // one random line with random syncs
    for (int i = 0; i < 16; i++) rand_px(255);

    // mid-line reset while valid pixels are streaming
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'(40 * i), 8'(200 - 30 * i), 8'(17 * i));
    assert_rst(2);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'(25 * i), 8'(60 + i), 8'(250 - 20 * i));

    // small-range values stress max ties and grey pixels
    for (int i = 0; i < 200; i++) rand_px(3);
    for (int i = 0; i < 300; i++) rand_px(255);

    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    @(negedge pixelclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
